// File: rtl/arbiter_16_rr_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
// The package is named arb_pkg so every file imports the same short name.
package arb_pkg;
  localparam int NUM_REQ      = 16;
  localparam int NREQ_W       = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/arbiter_16_rr_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface arbiter_16_rr_if;
  import arb_pkg::*;

  // Handshake: req[k] is a level that holds for as long as requester k needs
  // the resource. A grant is one-hot and stays constant until it is released.
  // Release happens at the edge that samples done=1, or req[grant_id]=0, or a
  // hold limit. timeout is a one-cycle pulse marking a limit-only release.
  // grant_id stays at its last value whenever grant_valid is low.
  logic               enable;
  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [NREQ_W-1:0]  grant_id;
  logic               grant_valid;
  logic               timeout;

  modport master (
    output enable, req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  enable, req, done,
    output grant, grant_id, grant_valid, timeout
  );
endinterface

// File: rtl/arbiter_16_rr_pri_enc.sv
// 16-to-4 priority encoder: the lowest set bit wins, and valid flags any set bit.
module pri_enc_16
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] in,
  output logic [NREQ_W-1:0]  idx,
  output logic               valid
);

  // Scanning from the top down leaves the lowest set index as the last write.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (in[i]) begin
        idx   = NREQ_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbiter_16_rr.sv
// Round-robin arbiter for 16 requesters. A grant is held until done, a request
// drop, or a hold limit; one idle cycle always separates consecutive grants.
module arbiter_16_rr
  import arb_pkg::*;
#(
  parameter int NREQ     = NUM_REQ,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  arbiter_16_rr_if.slave  bus,
  output state_t          state_dbg
);

  state_t              state;
  logic [NREQ_W-1:0]   ptr;
  logic [NREQ_W-1:0]   hold_cnt;
  logic [NREQ_W-1:0]   shift;
  logic [NREQ_W-1:0]   enc_idx;
  logic [NREQ_W-1:0]   winner;
  logic                enc_valid;
  logic [NREQ-1:0]     rot;
  logic [NREQ-1:0]     grant;
  logic [NREQ_W-1:0]   grant_id;
  logic                grant_valid;
  logic                timeout;
  logic                rel_done;
  logic                rel_drop;
  logic                rel_hold;

  // Rotating right by ptr+1 puts the requester just after the last holder at
  // bit 0; the 4-bit index arithmetic provides the wrap from 15 to 0.
  assign shift = ptr + 4'd1;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = bus.req[NREQ_W'(i) + shift];
    end
  end

  pri_enc_16 u_enc (
    .in    (rot),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign winner   = enc_idx + shift;
  assign rel_done = bus.done;
  assign rel_drop = !bus.req[grant_id];
  assign rel_hold = (hold_cnt == NREQ_W'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      hold_cnt    <= '0;
      ptr         <= 4'd15;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable && enc_valid) begin
            grant       <= NREQ'(1) << winner;
            grant_id    <= winner;
            grant_valid <= 1'b1;
            hold_cnt    <= 4'd1;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (rel_done || rel_drop || rel_hold) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_id;
            timeout     <= rel_hold && !rel_done && !rel_drop;
            state       <= IDLE;
          end else if (hold_cnt != 4'd15) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_id    = grant_id;
  assign bus.grant_valid = grant_valid;
  assign bus.timeout     = timeout;
  assign state_dbg       = state;

endmodule
